// File: rtl/traffic_phase_controller.sv
// Two-road intersection controller with clearance, pedestrian walk
// service and a night flashing mode; lamps decode directly from state.
module traffic_phase_controller #(
  parameter int CLK_DIV       = 10,
  parameter int GREEN_TICKS   = 10,
  parameter int YELLOW_TICKS  = 3,
  parameter int ALL_RED_TICKS = 1,
  parameter int WALK_TICKS    = 4,
  parameter int TMR_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ped_req_v,
  input  logic       ped_req_h,
  input  logic       flash_en,
  output logic [2:0] v_light,
  output logic [2:0] h_light,
  output logic       walk_v,
  output logic       walk_h,
  output logic [2:0] phase
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(CLK_DIV - 1);

  localparam logic [TMR_W-1:0] G_LAST = TMR_W'(GREEN_TICKS - 1);
  localparam logic [TMR_W-1:0] Y_LAST = TMR_W'(YELLOW_TICKS - 1);
  localparam logic [TMR_W-1:0] R_LAST = TMR_W'(ALL_RED_TICKS - 1);
  localparam logic [TMR_W-1:0] WALK_T = TMR_W'(WALK_TICKS);

  localparam logic [2:0] V_GREEN   = 3'd0;
  localparam logic [2:0] V_YELLOW  = 3'd1;
  localparam logic [2:0] ALL_RED_A = 3'd2;
  localparam logic [2:0] H_GREEN   = 3'd3;
  localparam logic [2:0] H_YELLOW  = 3'd4;
  localparam logic [2:0] ALL_RED_B = 3'd5;
  localparam logic [2:0] FLASH     = 3'd6;

  if (CLK_DIV < 1 || GREEN_TICKS < 2 || YELLOW_TICKS < 1 ||
      ALL_RED_TICKS < 1 || WALK_TICKS < 1 ||
      WALK_TICKS >= GREEN_TICKS ||
      GREEN_TICKS > (2 ** TMR_W) ||
      YELLOW_TICKS > (2 ** TMR_W) ||
      ALL_RED_TICKS > (2 ** TMR_W)) begin : g_bad_param
    $error("traffic_phase_controller: illegal timing parameters");
  end

  logic [PW-1:0]    ps_q;
  logic             tick;
  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [TMR_W-1:0] tmr_q;
  logic [TMR_W-1:0] last;
  logic             expire;
  logic             tog_q;
  logic             pend_v_q;
  logic             pend_h_q;
  logic             serve_v_q;
  logic             serve_h_q;
  logic             enter_v;
  logic             enter_h;

  // Free-running prescaler, independent of the phase sequence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ps_q <= '0;
    else if (ps_q == PS_LAST) ps_q <= '0;
    else ps_q <= ps_q + PW'(1);
  end

  assign tick = (ps_q == PS_LAST);

  always_comb begin
    last = R_LAST;
    unique case (state_q)
      V_GREEN, H_GREEN:   last = G_LAST;
      V_YELLOW, H_YELLOW: last = Y_LAST;
      default:            last = R_LAST;
    endcase
  end

  assign expire = tick && (tmr_q == last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ALL_RED_B;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      V_GREEN:   if (expire) state_d = V_YELLOW;
      V_YELLOW:  if (expire) state_d = ALL_RED_A;
      ALL_RED_A: if (expire) state_d = H_GREEN;
      H_GREEN:   if (expire) state_d = H_YELLOW;
      H_YELLOW:  if (expire) state_d = ALL_RED_B;
      ALL_RED_B: if (expire) state_d = flash_en ? FLASH : V_GREEN;
      FLASH:     if (tick && !flash_en) state_d = ALL_RED_B;
      default:   state_d = ALL_RED_B;
    endcase
  end

  assign enter_v = (state_d == V_GREEN) && (state_q != V_GREEN);
  assign enter_h = (state_d == H_GREEN) && (state_q != H_GREEN);

  // Timer holds at zero in FLASH; only the toggle runs there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q <= '0;
      tog_q <= 1'b0;
    end else begin
      if (state_d != state_q) tmr_q <= '0;
      else if (tick && state_q != FLASH) tmr_q <= tmr_q + TMR_W'(1);
      if (state_q == FLASH && state_d == FLASH) begin
        if (tick) tog_q <= ~tog_q;
      end else begin
        tog_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v_q  <= 1'b0;
      pend_h_q  <= 1'b0;
      serve_v_q <= 1'b0;
      serve_h_q <= 1'b0;
    end else begin
      pend_v_q <= enter_v ? 1'b0 : (pend_v_q | ped_req_v);
      pend_h_q <= enter_h ? 1'b0 : (pend_h_q | ped_req_h);
      if (enter_v) serve_v_q <= pend_v_q | ped_req_v;
      if (enter_h) serve_h_q <= pend_h_q | ped_req_h;
    end
  end

  always_comb begin
    v_light = 3'b001;
    h_light = 3'b001;
    walk_v  = 1'b0;
    walk_h  = 1'b0;
    phase   = state_q;
    unique case (state_q)
      V_GREEN: begin
        v_light = 3'b100;
        walk_v  = serve_v_q && (tmr_q < WALK_T);
      end
      V_YELLOW: v_light = 3'b010;
      H_GREEN: begin
        h_light = 3'b100;
        walk_h  = serve_h_q && (tmr_q < WALK_T);
      end
      H_YELLOW: h_light = 3'b010;
      FLASH: begin
        v_light = tog_q ? 3'b010 : 3'b000;
        h_light = tog_q ? 3'b001 : 3'b000;
      end
      default: ;
    endcase
  end

endmodule
